// File: rtl/sram_image_reader_pkg.sv
// Shared types for the SRAM image reader: FSM encoding and the sideband
// bundle that travels alongside each read.
package sram_image_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } rd_state_t;

  // Buffer entry layout is {flags, data}; flags sit in the top bits.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_flags_t;

  localparam int FLAGS_W = $bits(pix_flags_t);

endpackage

// File: rtl/sram_rd_skid.sv
// Two-entry FIFO that catches SRAM read returns. The head is presented from
// registers and reads as zero when the FIFO is empty.
module sram_rd_skid
  import sram_image_reader_pkg::*;
#(
  parameter int WIDTH = 8 + FLAGS_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign occupancy = count_q;
  assign pop_ok    = pop && out_valid;

  // Pointer and count update; push and pop may happen in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_image_reader.sv
// Streams an img_w x img_h rectangle out of block SRAM as a valid/ready
// pixel stream with sof/eol/eof markers.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; operands latched when it is accepted
//   ST_ISSUE | one SRAM read per cycle whenever a buffer slot is free
//   ST_DRAIN | all reads issued; waiting for the eof pixel to be accepted
//   ST_FIN   | one-cycle done pulse, then back to idle
module sram_image_reader
  import sram_image_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  img_w,
  input  logic [DIM_WIDTH-1:0]  img_h,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof
);

  localparam int BW = DATA_WIDTH + FLAGS_W;

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DIM_WIDTH-1:0]  x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic                  inflight_q, inflight_d;
  pix_flags_t            sb_q, sb_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic                  head_valid, pop, issue, last_x, last_y;
  logic [BW-1:0]         head_data;
  logic [1:0]            occ;
  logic [2:0]            used;
  pix_flags_t            head_flags;

  sram_rd_skid #(.WIDTH(BW)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data ({sb_q, sram_data}),
    .pop       (pop),
    .out_valid (head_valid),
    .out_data  (head_data),
    .occupancy (occ)
  );

  assign head_flags = head_data[BW-1 -: FLAGS_W];
  assign pop        = head_valid && pix_ready;
  assign last_x     = (x_q == w_q - DIM_WIDTH'(1));
  assign last_y     = (y_q == h_q - DIM_WIDTH'(1));

  // A head being accepted this cycle frees its slot at the same edge the new
  // read's data would land, so it counts as credit; this keeps 1 pixel/cycle.
  assign used  = {1'b0, occ} + {2'b00, inflight_q};
  assign issue = (state_q == ST_ISSUE) && (used < (3'd2 + {2'b00, pop}));

  assign sram_en   = issue;
  assign sram_we   = 1'b0;
  assign sram_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_valid = head_valid;
  assign pix_data  = head_data[DATA_WIDTH-1:0];
  assign pix_sof   = head_flags.sof;
  assign pix_eol   = head_flags.eol;
  assign pix_eof   = head_flags.eof;

  // Next-state, raster counters and sideband for the read being issued.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    inflight_d = issue;
    sb_d       = '0;
    if (issue) begin
      sb_d.sof = (x_q == '0) && (y_q == '0);
      sb_d.eol = last_x;
      sb_d.eof = last_x && last_y;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d    = img_w;
          h_d    = img_h;
          addr_d = base_addr;
          x_d    = '0;
          y_d    = '0;
          state_d = (img_w == '0 || img_h == '0) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (last_x) begin
            x_d = '0;
            y_d = y_q + DIM_WIDTH'(1);
            if (last_y) state_d = ST_DRAIN;
          end else begin
            x_d = x_q + DIM_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pop && head_flags.eof && !inflight_q) state_d = ST_FIN;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // All control state, with busy/done registered alongside the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      inflight_q <= 1'b0;
      sb_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      inflight_q <= inflight_d;
      sb_q       <= sb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule
